serial_debug: RTL and testbench

//  Debug message transmitter: latches a fixed-length ASCII message (MSG_LEN bytes) on a send

---
 rtl/serial_debug.sv | 201 ++++++++++++++++++++
 tb/tb_serial_debug.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_debug.sv
// serial_debug: fixed-length debug message transmitter over an 8N1 UART line.
// A send strobe latches MSG_LEN bytes, which go out most-significant byte first
// with each byte sent LSB first. The 'block' input holds off byte starts.
// Optional build macro: SERIAL_DEBUG_SKIP_NUL_EN -- when defined, 8'h00 bytes are
// dropped from the line at a cost of one clock cycle per dropped byte.
module serial_debug #(
    parameter int CLK_PER_BIT = 434,
    parameter int MSG_LEN     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   block,
    input  logic                   send,
    input  logic [8*MSG_LEN-1:0]   data,
    output logic                   busy,
    output logic                   tx
);

    localparam int DW = 8 * MSG_LEN;
    localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT,
        S_SKIP
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   shift_r;      // byte on the line is always the top byte
    logic [IW-1:0]   idx_r;        // bytes left after the current one
    logic [TW-1:0]   timer_r;
    logic [2:0]      bit_r;
    logic            busy_flag_r;
    logic            tx_r;

    logic [7:0]      cur_byte_s;
    logic [DW-1:0]   next_shift_s;
    logic            bit_end_s;
    logic            accept_s;
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
    logic [7:0]      next_byte_s;
    logic [7:0]      data_top_s;
`endif

    // Decode the current byte, bit-period end and accept condition.
    always_comb begin
        cur_byte_s   = shift_r[DW-1 -: 8];
        next_shift_s = shift_r << 8;
        bit_end_s    = (timer_r == LAST_TICK);
        accept_s     = (state_r == S_IDLE) && send && !busy_flag_r && !block;
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
        next_byte_s  = next_shift_s[DW-1 -: 8];
        data_top_s   = data[DW-1 -: 8];
`endif
    end

    // Transmit FSM: message framing, bit timing and the registered tx line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            shift_r     <= '0;
            idx_r       <= '0;
            timer_r     <= '0;
            bit_r       <= 3'd0;
            busy_flag_r <= 1'b0;
            tx_r        <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    timer_r <= '0;
                    bit_r   <= 3'd0;
                    if (accept_s) begin
                        shift_r     <= data;
                        idx_r       <= LAST_IDX;
                        busy_flag_r <= 1'b1;
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
                        if (data_top_s == 8'h00) begin
                            state_r <= S_SKIP;
                            tx_r    <= 1'b1;
                        end else begin
                            state_r <= S_START;
                            tx_r    <= 1'b0;
                        end
`else
                        state_r <= S_START;
                        tx_r    <= 1'b0;
`endif
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        timer_r <= '0;
                        bit_r   <= 3'd0;
                        state_r <= S_DATA;
                        tx_r    <= cur_byte_s[0];
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        timer_r <= '0;
                        if (bit_r == 3'd7) begin
                            state_r <= S_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                            tx_r  <= cur_byte_s[bit_r + 3'd1];
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        timer_r <= '0;
                        bit_r   <= 3'd0;
                        if (idx_r == '0) begin
                            state_r     <= S_IDLE;
                            busy_flag_r <= 1'b0;
                        end else begin
                            shift_r <= next_shift_s;
                            idx_r   <= idx_r - IW'(1);
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
                            if (next_byte_s == 8'h00) begin
                                state_r <= S_SKIP;
                            end else if (block) begin
                                state_r <= S_WAIT;
                            end else begin
                                state_r <= S_START;
                                tx_r    <= 1'b0;
                            end
`else
                            if (block) begin
                                state_r <= S_WAIT;
                            end else begin
                                state_r <= S_START;
                                tx_r    <= 1'b0;
                            end
`endif
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_WAIT: begin
                    // Line stays idle-high until the bridge can take the next byte.
                    timer_r <= '0;
                    if (!block) begin
                        state_r <= S_START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                S_SKIP: begin
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
                    // Top byte is NUL: drop it in a single cycle.
                    timer_r <= '0;
                    if (idx_r == '0) begin
                        state_r     <= S_IDLE;
                        busy_flag_r <= 1'b0;
                    end else begin
                        shift_r <= next_shift_s;
                        idx_r   <= idx_r - IW'(1);
                        if (next_byte_s == 8'h00) begin
                            state_r <= S_SKIP;
                        end else if (block) begin
                            state_r <= S_WAIT;
                        end else begin
                            state_r <= S_START;
                            tx_r    <= 1'b0;
                        end
                    end
`else
                    state_r     <= S_IDLE;
                    busy_flag_r <= 1'b0;
                    tx_r        <= 1'b1;
`endif
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_flag_r <= 1'b0;
                    tx_r        <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_flag_r | block;
    assign tx   = tx_r;

endmodule

// File: tb/tb_serial_debug.sv
// Directed testbench for serial_debug with a short bit period.
module tb_serial_debug;

    localparam int N = 8;
    localparam int M = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           block = 1'b0;
    logic           send = 1'b0;
    logic [8*M-1:0] data = '0;
    logic           busy;
    logic           tx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_frames = 0;
    logic [7:0] first_byte = 8'h00;

    serial_debug #(.CLK_PER_BIT(N), .MSG_LEN(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .block (block),
        .send  (send),
        .data  (data),
        .busy  (busy),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receive one 8N1 frame by mid-bit sampling; optionally raise block or re-pulse send.
    task automatic get_byte(input int blk_bit, input bit resend, input logic [8*M-1:0] d2,
                            output logic [7:0] b, output bit framed, output bit found);
        int n;
        n = 0;
        b = 8'h00;
        framed = 1'b1;
        found = 1'b1;
        while (tx !== 1'b0 && n < 40 * N) begin
            tick();
            n++;
        end
        if (tx !== 1'b0) begin
            found = 1'b0;
            return;
        end
        if (resend) begin
            data = d2;
            send = 1'b1;
        end
        repeat (N / 2) begin
            tick();
            send = 1'b0;
        end
        if (tx !== 1'b0) framed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (N) tick();
            b[i] = tx;
            if (i == blk_bit) block = 1'b1;
        end
        repeat (N) tick();
        if (tx !== 1'b1) framed = 1'b0;
    endtask

    // Send one message and decode it, checking bytes, framing, block hold and duration.
    task automatic run_msg(input logic [8*M-1:0] d, input int blk_frame, input int resend_frame,
                           input logic [8*M-1:0] d2, input string name);
        logic [7:0] exp_q[$];
        logic [7:0] c;
        logic [7:0] b;
        bit framed;
        bit found;
        bit first_imm;
        int skips;
        int a;
        int n;
        int hold_bad;
        int exp_dur;
        skips = 0;
        for (int k = M - 1; k >= 0; k--) begin
            c = d[8*k +: 8];
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
            if (c == 8'h00) skips++;
            else exp_q.push_back(c);
`else
            exp_q.push_back(c);
`endif
        end
        c = d[8*M-1 -: 8];
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
        first_imm = (c != 8'h00);
`else
        first_imm = 1'b1;
`endif
        exp_dur = skips + exp_q.size() * 10 * N;
        last_frames = 0;
        data = d;
        send = 1'b1;
        tick();
        send = 1'b0;
        a = cyc;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_accept got=%b exp=1", name, busy);
        end
        if (first_imm) begin
            total++;
            if (tx !== 1'b0) begin
                bad++;
                $display("FAIL %s start_next_cycle got=%b exp=0", name, tx);
            end
        end
        for (int f = 0; f < exp_q.size(); f++) begin
            get_byte((f == blk_frame) ? 3 : -1, (f == resend_frame), d2, b, framed, found);
            total++;
            if (!found) begin
                bad++;
                $display("FAIL %s frame%0d_timeout got=none exp=start_bit", name, f);
                break;
            end
            last_frames++;
            if (f == 0) first_byte = b;
            if (b !== exp_q[f]) begin
                bad++;
                $display("FAIL %s byte%0d got=%h exp=%h", name, f, b, exp_q[f]);
            end
            total++;
            if (!framed) begin
                bad++;
                $display("FAIL %s frame%0d_bits got=bad_start_or_stop exp=0_then_1", name, f);
            end
            if (f == blk_frame && f < exp_q.size() - 1) begin
                hold_bad = 0;
                repeat (2 * N) begin
                    tick();
                    if (tx !== 1'b1 || busy !== 1'b1) hold_bad++;
                end
                total++;
                if (hold_bad != 0) begin
                    bad++;
                    $display("FAIL %s block_hold got=%0d_bad_cycles exp=0", name, hold_bad);
                end
                block = 1'b0;
                tick();
                total++;
                if (tx !== 1'b0) begin
                    bad++;
                    $display("FAIL %s resume_after_block got=%b exp=0", name, tx);
                end
            end
        end
        n = 0;
        while (busy !== 1'b0 && n < 20 * N) begin
            tick();
            n++;
        end
        if (blk_frame < 0) begin
            total++;
            if (cyc - a != exp_dur) begin
                bad++;
                $display("FAIL %s busy_duration got=%0d exp=%0d", name, cyc - a, exp_dur);
            end
        end
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end_idle got=tx%b_busy%b exp=tx1_busy0", name, tx, busy);
        end
    endtask

    task automatic test_reset();
        int hi_bad;
        rst = 1'b1;
        block = 1'b0;
        repeat (5) tick();
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=tx%b_busy%b exp=tx1_busy0", tx, busy);
        end
        rst = 1'b0;
        block = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_follows_block got=%b exp=1", busy);
        end
        data = "IGNORED_MESSAGE!";
        send = 1'b1;
        tick();
        send = 1'b0;
        hi_bad = 0;
        repeat (30) begin
            tick();
            if (tx !== 1'b1) hi_bad++;
        end
        total++;
        if (hi_bad != 0) begin
            bad++;
            $display("FAIL blocked_send_tx got=%0d_low_cycles exp=0", hi_bad);
        end
        block = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL blocked_send_not_queued got=tx%b_busy%b exp=tx1_busy0", tx, busy);
        end
    endtask

    task automatic test_message();
        logic [8*M-1:0] m;
        m = "Time: 1000 \n";
        run_msg(m, -1, -1, '0, "message");
        total++;
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
        if (last_frames != 12) begin
            bad++;
            $display("FAIL message_frames got=%0d exp=12", last_frames);
        end
`else
        if (last_frames != 16 || first_byte !== 8'h00) begin
            bad++;
            $display("FAIL message_frames got=%0d_first%h exp=16_first00", last_frames, first_byte);
        end
`endif
    endtask

    task automatic test_resend();
        logic [8*M-1:0] m1;
        logic [8*M-1:0] m2;
        m1 = "0123456789abcdef";
        m2 = "zzzzzzzzzzzzzzzz";
        run_msg(m1, -1, 2, m2, "resend");
    endtask

    task automatic test_block();
        logic [8*M-1:0] m;
        m = "ABCDEFGHIJKLMNOP";
        run_msg(m, 2, -1, '0, "block");
    endtask

    task automatic test_rst_mid();
        logic [8*M-1:0] m;
        m = "QRSTUVWXYZqrstuv";
        data = m;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (3 * N + 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_abort got=tx%b_busy%b exp=tx1_busy0", tx, busy);
        end
        tick();
        m = "after reset msg!";
        run_msg(m, -1, -1, '0, "post_reset");
    endtask

    task automatic test_all_zero();
        run_msg('0, -1, -1, '0, "all_zero");
    endtask

`ifdef SERIAL_DEBUG_SKIP_NUL_EN
    task automatic test_skip_nul();
        logic [8*M-1:0] m;
        m = "Time: 1000 \n";
        run_msg(m, -1, -1, '0, "skip_nul");
        total++;
        if (last_frames != 12 || first_byte !== 8'h54) begin
            bad++;
            $display("FAIL skip_nul_frames got=%0d_first%h exp=12_first54", last_frames, first_byte);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_message();
        test_resend();
        test_block();
        test_rst_mid();
        test_all_zero();
`ifdef SERIAL_DEBUG_SKIP_NUL_EN
        test_skip_nul();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
